// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters: data-first priority with a fetch anti-starvation
// streak limit; 2-cycle minimum req->ready latency; requesters stall by holding req until their ready pulse.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

    state_t        r_state, w_next_state;
    logic [SW-1:0] r_dstreak;
    logic [CW-1:0] r_tcount;
    logic          r_mem_req, r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          w_busy, w_timeout, w_done, w_grant_d, w_grant_i;

    always_comb begin
        w_busy    = (r_state != IDLE);
        // An ack arriving on the last allowed cycle beats the watchdog.
        w_timeout = (TIMEOUT != 0) && w_busy && !mem_ack && (r_tcount == CW'(TIMEOUT - 1));
        w_done    = w_busy && (mem_ack || w_timeout);
        w_grant_d = (r_state == IDLE) && d_req && (!if_req || (r_dstreak < SW'(MAX_DSTREAK)));
        w_grant_i = (r_state == IDLE) && !w_grant_d && if_req;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next_state = DBUSY;
                else if (w_grant_i) w_next_state = IBUSY;
            end
            IBUSY, DBUSY: begin
                if (w_done) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        if_ready = (r_state == IBUSY) && w_done;
        if_err   = if_ready && !mem_ack;
        if_rdata = ((r_state == IBUSY) && mem_ack) ? mem_rdata : 32'h0;
        d_ready  = (r_state == DBUSY) && w_done;
        d_err    = d_ready && !mem_ack;
        d_rdata  = ((r_state == DBUSY) && mem_ack) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dstreak   <= '0;
            r_tcount    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_mem_be    <= d_be;
                // Streak only counts data grants that made a waiting fetch wait longer.
                if (!if_req)
                    r_dstreak <= '0;
                else if (r_dstreak != SW'(MAX_DSTREAK))
                    r_dstreak <= r_dstreak + SW'(1);
            end else if (w_grant_i) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= if_addr;
                r_mem_be   <= 4'hF;
                r_dstreak  <= '0;
            end
            if (w_busy) begin
                r_tcount <= w_done ? '0 : r_tcount + CW'(1);
                if (w_done) r_mem_req <= 1'b0;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the pipeline's instruction-fetch requester and its data (lw/sw) requester.
- Sits between the fetch/memory stages and the memory model.
- Arbitration is fixed-priority with data first, plus an anti-starvation streak limit for fetch.
- Tracks a single outstanding transaction with a bus-timeout watchdog; stall logic holds each requester until its ready pulse.

Parameters:
AW, 32, address width
MAX_DSTREAK, 4, max consecutive data grants while fetch is waiting before fetch is forced
TIMEOUT, 64, cycles in BUSY without mem_ack before abort; 0 disables the watchdog
CW, 8, width of the timeout counter; must satisfy 2^CW > TIMEOUT

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_ready
if_addr  in  AW  fetch address
if_rdata  out  32  fetch data, valid with if_ready
if_ready  out  1  one-cycle completion pulse to fetch
if_err  out  1  fetch aborted by timeout, valid with if_ready
d_req  in  1  data request; held with fields stable until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  32  store data
d_be  in  4  store byte enables
d_rdata  out  32  load data, valid with d_ready
d_ready  out  1  one-cycle completion pulse to data
d_err  out  1  data aborted by timeout, valid with d_ready
mem_req  out  1  memory request; held until mem_ack or abort
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables; 4'hF for fetch
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; dstreak=0; tcount=0.
  - All mem_* registers 0, so mem_req drops immediately, including mid-transaction.
  - All ready/err outputs 0.
- States: IDLE, IBUSY, DBUSY.
- IDLE grant, evaluated each cycle:
  - d_req && (!if_req || dstreak<MAX_DSTREAK) -> DBUSY.
  - else if if_req -> IBUSY.
  - else stay IDLE.
- Granting registers the owner's fields into mem_addr/mem_we/mem_wdata/mem_be and sets mem_req=1 on the next edge.
  - Fetch grant drives mem_we=0, mem_be=4'hF.
- dstreak update at each grant:
  - Data grant with if_req=1: dstreak+1, saturating at MAX_DSTREAK.
  - Data grant with if_req=0: dstreak=0.
  - Fetch grant: dstreak=0.
- BUSY:
  - mem_req and fields stay stable until the transaction ends.
  - tcount increments every BUSY cycle.
- Completion (BUSY && mem_ack):
  - Owner's ready=1 combinationally in the same cycle; owner's rdata = mem_rdata passthrough; err=0.
  - Next edge: state=IDLE, mem_req=0, tcount=0.
- Timeout (TIMEOUT!=0 && tcount==TIMEOUT-1 && !mem_ack):
  - Owner's ready=1, err=1, rdata=32'h0.
  - Next edge: IDLE, mem_req=0.
  - If mem_ack arrives in that same cycle, the ack wins and err=0.
- IDLE always lasts at least one cycle between transactions; no back-to-back grant on the ack cycle. Minimum latency is 2 cycles from req to ready (grant edge, then ack in the first BUSY cycle).
- mem_ack in IDLE is ignored: no ready pulse, no state change.
- Non-owner ready/err/rdata: held at 0.
- Request dropped before ready is a protocol violation; the outstanding transaction still completes.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x100, mem_be=F, mem_we=0; if_ready pulses with if_rdata=0x00500093; total latency 2 cycles.
- Simultaneous requests: if_req=d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> data granted first with mem_we=1 and matching fields; d_ready pulses; one IDLE cycle; then fetch granted.
- Starvation limit: MAX_DSTREAK=4, d_req and if_req held continuously, ack after 1 cycle -> grant order D,D,D,D,I,D...; dstreak reads 0 after the fetch grant.
- Timeout: TIMEOUT=8, d_req load, mem_ack never asserted -> d_ready=1, d_err=1, d_rdata=0 in the 8th BUSY cycle; mem_req=0 on the next edge; a late mem_ack in IDLE produces no pulse.
- Ack/timeout race: TIMEOUT=8, mem_ack in the 8th BUSY cycle -> d_ready=1, d_err=0, d_rdata=mem_rdata.
- Reset mid-transaction: reset_n low while in IBUSY -> mem_req=0 immediately (asynchronous), no if_ready; after release with if_req still high, fetch is re-granted from IDLE.
